// File: rtl/moore_bcd_counter.sv
// moore_bcd_counter: divided-tick Moore up/down BCD counter with load, limit flags and 7-segment outputs.
// Define MOORE_BCD_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module moore_bcd_counter #(
    parameter int DIGITS    = 2,
    parameter int DIV       = 25000000,
    parameter int MAX_COUNT = 99,
    parameter int WRAP      = 1
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                up_i,
    input  logic                down_i,
    input  logic                load_i,
    input  logic [4*DIGITS-1:0] load_value_i,
    output logic [4*DIGITS-1:0] count_o,
    output logic [7*DIGITS-1:0] display_o,
    output logic                tick_o,
    output logic                at_max_o,
    output logic                at_min_o
);
    localparam int W  = 4 * DIGITS;
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic              tick_q, tick_d;
    logic [W-1:0]      count_q, count_d, inc_v, dec_v;
    logic [DIGITS-1:0] cy, bw, bad_dig;
    logic              load_bad;

    assign cy[0] = 1'b1;
    assign bw[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] d;
        assign d = count_q[4*g+:4];
        assign inc_v[4*g+:4] = cy[g] ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
        assign dec_v[4*g+:4] = bw[g] ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
        assign bad_dig[g] = load_value_i[4*g+:4] > 4'd9;
        if (g < DIGITS - 1) begin : g_chain
            assign cy[g+1] = cy[g] & (d == 4'd9);
            assign bw[g+1] = bw[g] & (d == 4'd0);
        end
`ifdef MOORE_BCD_BLANK_EN
        if (g == 0) begin : g_lsd
            assign display_o[7*g+:7] = seg7(d);
        end else begin : g_msd
            assign display_o[7*g+:7] = count_q[W-1:4*g] == '0 ? 7'b1111111 : seg7(d);
        end
`else
        assign display_o[7*g+:7] = seg7(d);
`endif
    end

    assign load_bad = |bad_dig || load_value_i > MAX_BCD;
    assign at_max_o = count_q == MAX_BCD;
    assign at_min_o = count_q == '0;
    assign count_o  = count_q;
    assign tick_o   = tick_q;

    // Limits are checked before stepping, so a MAX_COUNT that is not all nines still wraps cleanly.
    always_comb begin
        state_d = up_i & ~down_i ? UP : (down_i & ~up_i ? DOWN : IDLE);
        div_d   = (load_i || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d  = div_d == DIV_LAST;
        count_d = count_q;
        if (load_i)
            count_d = load_bad ? MAX_BCD : load_value_i;
        else if (tick_q && state_q == UP)
            count_d = at_max_o ? (WRAP != 0 ? '0 : count_q) : inc_v;
        else if (tick_q && state_q == DOWN)
            count_d = at_min_o ? (WRAP != 0 ? MAX_BCD : count_q) : dec_v;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_moore_bcd_counter.sv
// tb_moore_bcd_counter: checks wrap and saturate instances against a decimal reference model.
module tb_moore_bcd_counter;
    localparam int DIV = 4;
    localparam int MAXC = 59;
`ifdef MOORE_BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic clk = 1'b0, rst_n = 1'b0, up = 1'b0, down = 1'b0, load = 1'b0;
    logic [7:0] lv = '0;
    logic [7:0] cnt_w, cnt_s;
    logic [13:0] disp_w, disp_s;
    logic tick_w, tick_s, max_w, max_s, min_w, min_s;
    int checks = 0, errors = 0;
    int mw, ms, mdir, mcyc;

    always #5 clk = ~clk;

    moore_bcd_counter #(.DIGITS(2), .DIV(DIV), .MAX_COUNT(MAXC), .WRAP(1)) dut_w (
        .clock_i(clk), .reset_ni(rst_n), .up_i(up), .down_i(down), .load_i(load),
        .load_value_i(lv), .count_o(cnt_w), .display_o(disp_w), .tick_o(tick_w),
        .at_max_o(max_w), .at_min_o(min_w));

    moore_bcd_counter #(.DIGITS(2), .DIV(DIV), .MAX_COUNT(MAXC), .WRAP(0)) dut_s (
        .clock_i(clk), .reset_ni(rst_n), .up_i(up), .down_i(down), .load_i(load),
        .load_value_i(lv), .count_o(cnt_s), .display_o(disp_s), .tick_o(tick_s),
        .at_max_o(max_s), .at_min_o(min_s));

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] exp_disp(int v);
        return {(BLANK && v < 10) ? 7'b1111111 : SEG[v/10], SEG[v%10]};
    endfunction

    function automatic int step(int v, int dir, bit wrap);
        if (dir > 0) return v == MAXC ? (wrap ? 0 : MAXC) : v + 1;
        if (dir < 0) return v == 0 ? (wrap ? MAXC : 0) : v - 1;
        return v;
    endfunction

    // Reference: decimal count, tick every DIV cycles since the last reset/load.
    always @(posedge clk) begin
        if (!rst_n) begin
            mw = 0; ms = 0; mdir = 0; mcyc = 0;
        end else begin
            if (load) begin
                if (lv[3:0] > 9 || lv[7:4] > 9 || lv[7:4] * 10 + lv[3:0] > MAXC) begin
                    mw = MAXC; ms = MAXC;
                end else begin
                    mw = lv[7:4] * 10 + lv[3:0]; ms = mw;
                end
                mcyc = 0;
            end else begin
                if (mcyc % DIV == DIV - 1) begin
                    mw = step(mw, mdir, 1'b1);
                    ms = step(ms, mdir, 1'b0);
                end
                mcyc++;
            end
            mdir = (up && !down) ? 1 : ((down && !up) ? -1 : 0);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cnt_w !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", cnt_w); end
        checks++; if (min_w !== 1'b1 || max_w !== 1'b0) begin errors++; $display("FAIL reset_flags got min=%b max=%b want 1 0", min_w, max_w); end
        checks++; if (tick_w !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick_w); end
        checks++; if (disp_w[6:0] !== 7'b1000000) begin errors++; $display("FAIL reset_disp0 got %b want 1000000", disp_w[6:0]); end
    endtask

    task automatic test_up_carry();
        int seen = 0, last_t = -1;
        load = 1'b1; lv = 8'h08;
        @(negedge clk);
        load = 1'b0; up = 1'b1;
        for (int c = 0; c < 12 && seen < 2; c++) begin
            @(negedge clk);
            if (tick_w === 1'b1) begin
                if (last_t >= 0) begin
                    checks++; if (c - last_t != DIV) begin errors++; $display("FAIL tick_period got %0d want %0d", c - last_t, DIV); end
                end
                last_t = c;
            end
            if (seen == 0 && cnt_w !== 8'h08) begin
                checks++; if (cnt_w !== 8'h09) begin errors++; $display("FAIL up_first got %h want 09", cnt_w); end
                seen = 1;
            end else if (seen == 1 && cnt_w !== 8'h09) begin
                checks++; if (cnt_w !== 8'h10) begin errors++; $display("FAIL up_carry got %h want 10", cnt_w); end
                seen = 2;
            end
        end
        checks++; if (seen != 2) begin errors++; $display("FAIL up_timeout got %0d steps want 2", seen); end
        up = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        load = 1'b1; lv = 8'h59;
        @(negedge clk);
        load = 1'b0;
        checks++; if (cnt_w !== 8'h59 || max_w !== 1'b1) begin errors++; $display("FAIL load_max got %h max=%b want 59 1", cnt_w, max_w); end
        up = 1'b1; n = 0;
        while (cnt_w === 8'h59 && n < 12) begin @(negedge clk); n++; end
        checks++; if (cnt_w !== 8'h00 || min_w !== 1'b1) begin errors++; $display("FAIL wrap_up got %h min=%b want 00 1", cnt_w, min_w); end
        up = 1'b0; down = 1'b1; n = 0;
        while (cnt_w === 8'h00 && n < 12) begin @(negedge clk); n++; end
        checks++; if (cnt_w !== 8'h59 || max_w !== 1'b1) begin errors++; $display("FAIL wrap_down got %h max=%b want 59 1", cnt_w, max_w); end
        down = 1'b0;
    endtask

    task automatic test_saturate();
        load = 1'b1; lv = 8'h59;
        @(negedge clk);
        load = 1'b0; up = 1'b1;
        for (int c = 0; c < 3 * DIV + 2; c++) begin
            @(negedge clk);
            checks++; if (cnt_s !== 8'h59) begin errors++; $display("FAIL sat_up got %h want 59", cnt_s); end
        end
        up = 1'b0; load = 1'b1; lv = 8'h00;
        @(negedge clk);
        load = 1'b0; down = 1'b1;
        for (int c = 0; c < 3 * DIV + 2; c++) begin
            @(negedge clk);
            checks++; if (cnt_s !== 8'h00) begin errors++; $display("FAIL sat_down got %h want 00", cnt_s); end
        end
        down = 1'b0;
    endtask

    task automatic test_illegal_both_reset();
        load = 1'b1; lv = 8'h7A;
        @(negedge clk);
        checks++; if (cnt_w !== 8'h59 || cnt_s !== 8'h59) begin errors++; $display("FAIL illegal_digit got %h/%h want 59", cnt_w, cnt_s); end
        lv = 8'h60;
        @(negedge clk);
        checks++; if (cnt_w !== 8'h59) begin errors++; $display("FAIL illegal_range got %h want 59", cnt_w); end
        lv = 8'h42;
        @(negedge clk);
        load = 1'b0; up = 1'b1; down = 1'b1;
        repeat (3 * DIV + 1) @(negedge clk);
        checks++; if (cnt_w !== 8'h42 || cnt_s !== 8'h42) begin errors++; $display("FAIL both_hold got %h/%h want 42", cnt_w, cnt_s); end
        up = 1'b0; down = 1'b0; load = 1'b1; lv = 8'h33; rst_n = 1'b0;
        @(negedge clk);
        checks++; if (cnt_w !== 8'h00 || min_w !== 1'b1) begin errors++; $display("FAIL reset_over_load got %h min=%b want 00 1", cnt_w, min_w); end
        load = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_blank();
        load = 1'b1; lv = 8'h05;
        @(negedge clk);
        load = 1'b0;
        checks++; if (disp_w[6:0] !== 7'b0010010) begin errors++; $display("FAIL blank_d0 got %b want 0010010", disp_w[6:0]); end
        checks++; if (disp_w[13:7] !== (BLANK ? 7'b1111111 : 7'b1000000)) begin
            errors++; $display("FAIL blank_d1 got %b want %b", disp_w[13:7], BLANK ? 7'b1111111 : 7'b1000000);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n = $urandom_range(0, 60) != 0;
            load  = $urandom_range(0, 15) == 0;
            lv    = 8'($urandom);
            up    = $urandom_range(0, 2) != 0;
            down  = $urandom_range(0, 2) == 0;
            @(negedge clk);
            checks++; if (cnt_w !== bcd(mw) || cnt_s !== bcd(ms)) begin
                errors++; $display("FAIL rand_count got %h/%h want %h/%h", cnt_w, cnt_s, bcd(mw), bcd(ms));
            end
            checks++; if (tick_w !== (mcyc % DIV == DIV - 1) || tick_s !== tick_w) begin
                errors++; $display("FAIL rand_tick got %b/%b want %b", tick_w, tick_s, mcyc % DIV == DIV - 1);
            end
            checks++; if (max_w !== (mw == MAXC) || min_w !== (mw == 0) || max_s !== (ms == MAXC) || min_s !== (ms == 0)) begin
                errors++; $display("FAIL rand_flags got %b%b/%b%b want %b%b/%b%b", max_w, min_w, max_s, min_s, mw == MAXC, mw == 0, ms == MAXC, ms == 0);
            end
            checks++; if (disp_w !== exp_disp(mw) || disp_s !== exp_disp(ms)) begin
                errors++; $display("FAIL rand_disp got %b/%b want %b/%b", disp_w, disp_s, exp_disp(mw), exp_disp(ms));
            end
        end
        rst_n = 1'b1; load = 1'b0; up = 1'b0; down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_carry();
        test_wrap();
        test_saturate();
        test_illegal_both_reset();
        test_blank();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/moore_bcd_counter.md
# moore_bcd_counter

Parametrised Moore up/down counter with an on-chip tick divider, multi-digit BCD count and per-digit 7-segment outputs. It is the next-generation counter/display block for the lab boards, replacing a fixed single-digit counter, its separate divider, its decoder and its single 7-segment driver with one block. It adds:

- configurable digit count and modulus;
- wrap or saturate mode;
- synchronous parallel load;
- limit flags.

## Interface
- DIGITS, 2: number of BCD digits; range 1–4.
- DIV, 25000000: Clock cycles per count tick; must be ≥1.
- MAX_COUNT, 99: terminal count in decimal; must be < 10^DIGITS.
- WRAP, 1: 1 = modulo (MAX_COUNT+1) counting; 0 = saturate at 0 and MAX_COUNT.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- Up  in  1  level request to count up.
- Down  in  1  level request to count down.
- Load  in  1  synchronous parallel load strobe.
- Load_Value  in  4*DIGITS  BCD load value; digit 0 = bits [3:0].
- Count  out  4*DIGITS  current BCD count, registered.
- Display  out  7*DIGITS  active-low segments; digit i at [7i+6:7i], bit 0 = a … bit 6 = g.
- Tick  out  1  one-Clock pulse per divider period, registered.
- At_Max  out  1  Count == MAX_COUNT.
- At_Min  out  1  Count == 0.

## Operation
- **Direction FSM (Moore).** States IDLE, UP, DOWN. It is updated every Clock edge from the inputs:
  - Up & !Down → UP;
  - Down & !Up → DOWN;
  - both high or both low → IDLE.
- **Divider.** Counts 0..DIV-1 and then returns to 0. Tick is set on the edge where the divider reaches DIV-1. With DIV=1, Tick stays high continuously.
- **Count update.** On an edge where Tick is high:
  - UP: BCD +1 with digit-to-digit carry.
  - DOWN: BCD −1 with borrow.
  - IDLE: hold.
- **Limits.**
  - Up at MAX_COUNT: WRAP=1 → 0; WRAP=0 → hold.
  - Down at 0: WRAP=1 → MAX_COUNT; WRAP=0 → hold.
- **Load.**
  - Priority: Reset > Load > tick update.
  - Load=1 writes Load_Value into Count on that edge, independent of Tick, and clears the divider to 0.
  - An illegal Load_Value loads MAX_COUNT instead. Illegal means any digit >9, or a value > MAX_COUNT.
- **Flags.** At_Max and At_Min are combinational decodes of the Count register.
- **Display.** Each digit is decoded combinationally from Count using active-low segments.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Reset values** (Reset low at an edge):
  - Count=0, FSM=IDLE, divider=0, Tick=0;
  - At_Min=1, At_Max=0;
  - every Display digit shows 1000000, or is blanked per Configuration.

## Timing
- An input change sampled at edge k sets the FSM state after edge k. Count moves at the first Tick edge after edge k; worst-case latency is DIV+1 cycles.
- Up or Down held continuously gives one step per DIV cycles.
- Load at edge k: Count = value after edge k. The next tick edge is DIV cycles later.
- Reset has priority over everything, including Load and Tick in the same cycle.
- Reset asserted mid-count aborts the count. Counting restarts from 0 with a full divider period.
- Count, Tick and FSM are registered. Display and the flags follow Count within the same cycle.

## Configuration
- Macro: MOORE_BCD_BLANK_EN.
- **Defined:** leading-zero blanking. Any digit above the most significant nonzero digit drives 1111111. Digit 0 is never blanked, so Count=0 shows a single "0".
- **Undefined:** all DIGITS digits are always decoded, including leading zeros.

## Test plan
- **Reset.** Params: DIGITS=2, DIV=4, MAX_COUNT=59, WRAP=1. Drive Reset=0 for 2 cycles, then 1. Required: Count=0x00, At_Min=1, Tick=0, Display[6:0]=1000000.
- **Up with carry.** Hold Up from Count=0x08. Required: 0x09 at the next tick, then 0x10. Tick pulses exactly every 4 cycles.
- **Wrap up.** Load 0x59, then Up for 1 tick → 0x00. Then Down for 1 tick → 0x59. At_Max=1 while Count is 0x59.
- **Saturate.** With WRAP=0, Up at 0x59 for 3 ticks → stays 0x59. Down at 0x00 → stays 0x00.
- **Illegal load, simultaneous inputs, reset priority.**
  - Load 0x7A → Count=0x59.
  - Up=Down=1 for 3 ticks → Count unchanged.
  - Reset and Load asserted in the same cycle → Count=0x00.
- **Blanking.** With MOORE_BCD_BLANK_EN defined and Count=0x05: digit1 = 1111111, digit0 = 0010010. Without the macro, digit1 = 1000000.
